// File: rtl/rr_pipe_stage.sv
// Read-register stage between rename and the reservation-station write port.
// Selects each source operand from ARF, ROB or its pending tag, and snoops the CDB both at load and while held.
module rr_pipe_stage #(
    parameter int WAYS = 2,
    parameter int DW   = 32,
    parameter int PRW  = 6,
    parameter int IW   = 164,
    parameter int NCDB = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [WAYS-1:0]      in_valid,
    output logic                 in_ready,
    input  logic [WAYS*IW-1:0]   in_info,
    input  logic [WAYS-1:0]      rs_lc,
    input  logic [WAYS-1:0]      rt_lc,
    input  logic [WAYS*DW-1:0]   rs_data_a,
    input  logic [WAYS*DW-1:0]   rt_data_a,
    input  logic [WAYS*DW-1:0]   rs_data_r,
    input  logic [WAYS*DW-1:0]   rt_data_r,
    input  logic [WAYS*PRW-1:0]  rs_prr,
    input  logic [WAYS*PRW-1:0]  rt_prr,
    input  logic [WAYS-1:0]      rs_den,
    input  logic [WAYS-1:0]      rt_den,
    input  logic [NCDB-1:0]      cdb_valid,
    input  logic [NCDB*PRW-1:0]  cdb_tag,
    input  logic [NCDB*DW-1:0]   cdb_data,
    output logic [WAYS-1:0]      out_valid,
    input  logic                 out_ready,
    output logic [WAYS*IW-1:0]   out_info,
    output logic [WAYS*DW-1:0]   out_rs_data,
    output logic [WAYS*DW-1:0]   out_rt_data,
    output logic [WAYS-1:0]      out_rs_rdy,
    output logic [WAYS-1:0]      out_rt_rdy
);

    // Operand value paired with its ready flag: {rdy, data}.
    typedef logic [DW:0] opnd_t;

    function automatic opnd_t pick_source(
        input logic          lc,
        input logic          den,
        input logic [DW-1:0] arf,
        input logic [DW-1:0] rob,
        input logic [PRW-1:0] prr
    );
        opnd_t o;
        o = '0;
        if (lc) begin
            o = {1'b1, arf};
        end else if (den) begin
            o = {1'b1, rob};
        end else begin
            o[PRW-1:0] = prr;
        end
        return o;
    endfunction

    // Scanning from the top port down lets the lowest-index match land last.
    function automatic opnd_t cdb_capture(
        input logic [PRW-1:0]       tag,
        input opnd_t                cur,
        input logic [NCDB-1:0]      cv,
        input logic [NCDB*PRW-1:0]  ct,
        input logic [NCDB*DW-1:0]   cd
    );
        opnd_t o;
        o = cur;
        if (!cur[DW]) begin
            for (int p = NCDB - 1; p >= 0; p--) begin
                if (cv[p] && (ct[p*PRW +: PRW] == tag)) begin
                    o = {1'b1, cd[p*DW +: DW]};
                end
            end
        end
        return o;
    endfunction

    logic                load;
    logic [WAYS*DW-1:0]  ld_rs_data;
    logic [WAYS*DW-1:0]  ld_rt_data;
    logic [WAYS-1:0]     ld_rs_rdy;
    logic [WAYS-1:0]     ld_rt_rdy;
    logic [WAYS*DW-1:0]  hd_rs_data;
    logic [WAYS*DW-1:0]  hd_rt_data;
    logic [WAYS-1:0]     hd_rs_rdy;
    logic [WAYS-1:0]     hd_rt_rdy;

    // Handshake: a group transfers out when out_valid!=0 and out_ready=1; a new group
    // is taken whenever in_ready=1, as a unit, with no partial acceptance. Flush blocks both.
    assign in_ready = ~flush & (~|out_valid | out_ready);
    assign load     = in_ready;

    always_comb begin
        ld_rs_data = '0;
        ld_rt_data = '0;
        ld_rs_rdy  = '0;
        ld_rt_rdy  = '0;
        hd_rs_data = '0;
        hd_rt_data = '0;
        hd_rs_rdy  = '0;
        hd_rt_rdy  = '0;
        for (int w = 0; w < WAYS; w++) begin
            {ld_rs_rdy[w], ld_rs_data[w*DW +: DW]} = cdb_capture(
                rs_prr[w*PRW +: PRW],
                pick_source(rs_lc[w], rs_den[w], rs_data_a[w*DW +: DW],
                            rs_data_r[w*DW +: DW], rs_prr[w*PRW +: PRW]),
                cdb_valid, cdb_tag, cdb_data);
            {ld_rt_rdy[w], ld_rt_data[w*DW +: DW]} = cdb_capture(
                rt_prr[w*PRW +: PRW],
                pick_source(rt_lc[w], rt_den[w], rt_data_a[w*DW +: DW],
                            rt_data_r[w*DW +: DW], rt_prr[w*PRW +: PRW]),
                cdb_valid, cdb_tag, cdb_data);
            // A pending held operand carries its tag in the low PRW bits of its data.
            {hd_rs_rdy[w], hd_rs_data[w*DW +: DW]} = cdb_capture(
                out_rs_data[w*DW +: PRW],
                {out_rs_rdy[w], out_rs_data[w*DW +: DW]},
                cdb_valid, cdb_tag, cdb_data);
            {hd_rt_rdy[w], hd_rt_data[w*DW +: DW]} = cdb_capture(
                out_rt_data[w*DW +: PRW],
                {out_rt_rdy[w], out_rt_data[w*DW +: DW]},
                cdb_valid, cdb_tag, cdb_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= '0;
            out_info    <= '0;
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_rs_rdy  <= '0;
            out_rt_rdy  <= '0;
        end else if (flush) begin
            out_valid <= '0;
        end else if (load) begin
            out_valid   <= in_valid;
            out_info    <= in_info;
            out_rs_data <= ld_rs_data;
            out_rt_data <= ld_rt_data;
            out_rs_rdy  <= ld_rs_rdy;
            out_rt_rdy  <= ld_rt_rdy;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (out_valid[w]) begin
                    out_rs_data[w*DW +: DW] <= hd_rs_data[w*DW +: DW];
                    out_rt_data[w*DW +: DW] <= hd_rt_data[w*DW +: DW];
                    out_rs_rdy[w]           <= hd_rs_rdy[w];
                    out_rt_rdy[w]           <= hd_rt_rdy[w];
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_pipe_stage.sv
// Bench for rr_pipe_stage: directed scenarios plus random traffic, scored against a
// per-operand behavioural model held in a queue of expected output groups.
module tb_rr_pipe_stage;

    localparam int WAYS = 2;
    localparam int DW   = 32;
    localparam int PRW  = 6;
    localparam int IW   = 164;
    localparam int NCDB = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [WAYS-1:0]      in_valid;
    logic                 in_ready;
    logic [WAYS*IW-1:0]   in_info;
    logic [WAYS-1:0]      rs_lc, rt_lc;
    logic [WAYS*DW-1:0]   rs_data_a, rt_data_a, rs_data_r, rt_data_r;
    logic [WAYS*PRW-1:0]  rs_prr, rt_prr;
    logic [WAYS-1:0]      rs_den, rt_den;
    logic [NCDB-1:0]      cdb_valid;
    logic [NCDB*PRW-1:0]  cdb_tag;
    logic [NCDB*DW-1:0]   cdb_data;
    logic [WAYS-1:0]      out_valid;
    logic                 out_ready;
    logic [WAYS*IW-1:0]   out_info;
    logic [WAYS*DW-1:0]   out_rs_data, out_rt_data;
    logic [WAYS-1:0]      out_rs_rdy, out_rt_rdy;

    rr_pipe_stage #(.WAYS(WAYS), .DW(DW), .PRW(PRW), .IW(IW), .NCDB(NCDB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_info(in_info),
        .rs_lc(rs_lc), .rt_lc(rt_lc),
        .rs_data_a(rs_data_a), .rt_data_a(rt_data_a),
        .rs_data_r(rs_data_r), .rt_data_r(rt_data_r),
        .rs_prr(rs_prr), .rt_prr(rt_prr),
        .rs_den(rs_den), .rt_den(rt_den),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_rs_rdy(out_rs_rdy), .out_rt_rdy(out_rt_rdy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [WAYS-1:0]    valid;
        logic [WAYS*IW-1:0] info;
        logic [DW-1:0]      rs_data [WAYS];
        logic [DW-1:0]      rt_data [WAYS];
        logic               rs_rdy  [WAYS];
        logic               rt_rdy  [WAYS];
    } grp_t;

    grp_t exp_q[$];
    grp_t mon_e;
    int   vectors = 0;
    int   errors  = 0;
    bit   started = 0;
    logic pred_accept = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Operand at load: ARF, else ROB, else first CDB port carrying its tag, else the tag.
    function automatic logic [DW:0] model_load_op(input logic lc, input logic den,
                                                  input logic [DW-1:0] a, input logic [DW-1:0] r,
                                                  input logic [PRW-1:0] tag);
        logic [DW-1:0] z;
        if (lc)  return {1'b1, a};
        if (den) return {1'b1, r};
        for (int p = 0; p < NCDB; p++)
            if (cdb_valid[p] && cdb_tag[p*PRW +: PRW] == tag) return {1'b1, cdb_data[p*DW +: DW]};
        z = '0;
        z[PRW-1:0] = tag;
        return {1'b0, z};
    endfunction

    function automatic logic [DW:0] model_snoop_op(input logic rdy, input logic [DW-1:0] d);
        if (rdy) return {1'b1, d};
        for (int p = 0; p < NCDB; p++)
            if (cdb_valid[p] && cdb_tag[p*PRW +: PRW] == d[PRW-1:0]) return {1'b1, cdb_data[p*DW +: DW]};
        return {1'b0, d};
    endfunction

    function automatic grp_t model_load();
        grp_t g;
        logic [DW:0] o;
        g.valid = in_valid;
        g.info  = in_info;
        for (int w = 0; w < WAYS; w++) begin
            o = model_load_op(rs_lc[w], rs_den[w], rs_data_a[w*DW +: DW], rs_data_r[w*DW +: DW], rs_prr[w*PRW +: PRW]);
            g.rs_rdy[w] = o[DW]; g.rs_data[w] = o[DW-1:0];
            o = model_load_op(rt_lc[w], rt_den[w], rt_data_a[w*DW +: DW], rt_data_r[w*DW +: DW], rt_prr[w*PRW +: PRW]);
            g.rt_rdy[w] = o[DW]; g.rt_data[w] = o[DW-1:0];
        end
        return g;
    endfunction

    function automatic grp_t model_hold(input grp_t g);
        grp_t h;
        logic [DW:0] o;
        h = g;
        for (int w = 0; w < WAYS; w++) begin
            if (g.valid[w]) begin
                o = model_snoop_op(g.rs_rdy[w], g.rs_data[w]);
                h.rs_rdy[w] = o[DW]; h.rs_data[w] = o[DW-1:0];
                o = model_snoop_op(g.rt_rdy[w], g.rt_data[w]);
                h.rt_rdy[w] = o[DW]; h.rt_data[w] = o[DW-1:0];
            end
        end
        return h;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance past the next rising edge and fold that edge's effect into the model.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (flush) exp_q.delete();
        else if (pred_accept) begin
            if (|in_valid) exp_q.push_back(model_load());
        end else if (exp_q.size() > 0) exp_q[0] = model_hold(exp_q[0]);
    endtask

    task automatic apply();
        pred_accept = !flush && (exp_q.size() == 0 || out_ready);
        #1;
        chk("in_ready", in_ready, pred_accept);
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = '0; in_info = '0; out_ready = 1;
        rs_lc = '0; rt_lc = '0; rs_den = '0; rt_den = '0;
        rs_data_a = '0; rt_data_a = '0; rs_data_r = '0; rt_data_r = '0;
        rs_prr = '0; rt_prr = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    function automatic logic [IW-1:0] rand_info();
        logic [IW-1:0] v;
        for (int b = 0; b < IW; b++) v[b] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic rand_inputs();
        in_valid  = WAYS'($urandom_range(0, 3));
        flush     = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        for (int w = 0; w < WAYS; w++) begin
            in_info[w*IW +: IW]   = rand_info();
            rs_lc[w]  = ($urandom_range(0, 2) == 0);
            rt_lc[w]  = ($urandom_range(0, 2) == 0);
            rs_den[w] = ($urandom_range(0, 2) == 0);
            rt_den[w] = ($urandom_range(0, 2) == 0);
            rs_data_a[w*DW +: DW] = $urandom;
            rt_data_a[w*DW +: DW] = $urandom;
            rs_data_r[w*DW +: DW] = $urandom;
            rt_data_r[w*DW +: DW] = $urandom;
            rs_prr[w*PRW +: PRW]  = PRW'($urandom_range(0, 7));
            rt_prr[w*PRW +: PRW]  = PRW'($urandom_range(0, 7));
        end
        for (int p = 0; p < NCDB; p++) begin
            cdb_valid[p]            = 1'($urandom_range(0, 1));
            cdb_tag[p*PRW +: PRW]   = PRW'($urandom_range(0, 7));
            cdb_data[p*DW +: DW]    = $urandom;
        end
    endtask

    task automatic set_t2();
        clear_inputs();
        in_valid = 2'b11;
        in_info[IW-1:0] = rand_info();
        in_info[2*IW-1:IW] = rand_info();
        rs_lc[0] = 1; rs_data_a[31:0] = 32'h1234;
        rt_lc[0] = 0; rt_den[0] = 1; rt_data_r[31:0] = 32'hABCD;
        rs_lc[1] = 0; rs_den[1] = 0; rs_prr[11:6] = 6'd17;
        rt_lc[1] = 1; rt_data_a[63:32] = 32'h5555_0001;
    endtask

    task automatic reset_mid_hold();
        rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, '0);
        chk("rst_out_info", out_info, '0);
        chk("rst_rs_data", out_rs_data, '0);
        chk("rst_rt_data", out_rt_data, '0);
        chk("rst_rdy", {out_rs_rdy, out_rt_rdy}, '0);
        exp_q.delete();
        clear_inputs();
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        #1;
        rst_n = 1;
        apply();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && started) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q[0];
                chk("out_valid", out_valid, mon_e.valid);
                chk("out_info", out_info, mon_e.info);
                for (int w = 0; w < WAYS; w++) begin
                    if (mon_e.valid[w]) begin
                        chk($sformatf("rs_w%0d", w), {out_rs_rdy[w], out_rs_data[w*DW +: DW]},
                            {mon_e.rs_rdy[w], mon_e.rs_data[w]});
                        chk($sformatf("rt_w%0d", w), {out_rt_rdy[w], out_rt_data[w*DW +: DW]},
                            {mon_e.rt_rdy[w], mon_e.rt_data[w]});
                    end
                end
                if (out_ready && !flush) void'(exp_q.pop_front());
            end else begin
                chk("idle_valid", out_valid, '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("init_out_valid", out_valid, '0);
        chk("init_out_data", {out_rs_data, out_rt_data, out_rs_rdy, out_rt_rdy}, '0);
        chk("init_in_ready", in_ready, 1);
        #9 rst_n = 1;
        started = 1;
        apply();

        // select from ARF / ROB / tag
        next_cycle(); set_t2(); apply();
        next_cycle();
        chk("t2_w0_rs", {out_rs_rdy[0], out_rs_data[31:0]}, {1'b1, 32'h1234});
        chk("t2_w0_rt", {out_rt_rdy[0], out_rt_data[31:0]}, {1'b1, 32'hABCD});
        chk("t2_w1_rs", {out_rs_rdy[1], out_rs_data[63:32]}, {1'b0, 32'h11});

        // capture bypass at load
        set_t2();
        cdb_valid = 2'b10; cdb_tag[11:6] = 6'd17; cdb_data[63:32] = 32'hCAFE;
        apply();
        next_cycle();
        chk("t3_w1_rs", {out_rs_rdy[1], out_rs_data[63:32]}, {1'b1, 32'hCAFE});

        // hold with snoop, then asynchronous reset while held
        set_t2(); apply();
        next_cycle();
        rand_inputs(); in_valid = 2'b11; flush = 0; out_ready = 0; cdb_valid = '0; apply();
        next_cycle();
        cdb_valid = 2'b11; cdb_tag = {6'd17, 6'd17}; cdb_data = {32'h1111, 32'hBEEF}; apply();
        next_cycle();
        chk("t4_w1_rs", {out_rs_rdy[1], out_rs_data[63:32]}, {1'b1, 32'hBEEF});
        cdb_valid = '0; apply();
        next_cycle();
        reset_mid_hold();

        // flush with a valid incoming group and out_ready=1
        next_cycle();
        rand_inputs(); in_valid = 2'b11; flush = 0; out_ready = 1; apply();
        next_cycle();
        rand_inputs(); in_valid = 2'b11; flush = 1; out_ready = 1; apply();
        next_cycle();
        chk("t5_flushed", out_valid, '0);
        clear_inputs(); apply();

        // back-to-back streaming
        for (int g = 0; g < 4; g++) begin
            next_cycle();
            rand_inputs(); in_valid = WAYS'($urandom_range(1, 3)); flush = 0; out_ready = 1; apply();
        end
        next_cycle(); clear_inputs(); apply();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            rand_inputs();
            apply();
        end

        for (int c = 0; c < 3; c++) begin
            next_cycle(); clear_inputs(); apply();
        end
        @(negedge clk);
        #1;
        chk("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
